bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 The block SHALL have one parameter: NDIGITS, default 4, the number of BCD digits per operand (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an addition.
REQ-005 The block SHALL have port a, input, 4*NDIGITS bits: operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 The block SHALL have port b, input, 4*NDIGITS bits: operand B, packed BCD, same packing as a.
REQ-007 The block SHALL have port cin, input, 1 bit: decimal carry into digit 0.
REQ-008 The block SHALL have port sum, output, 4*NDIGITS bits: packed BCD result.
REQ-009 The block SHALL have port cout, output, 1 bit: decimal carry out of the top digit.
REQ-010 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-012 The block SHALL have port err, output, 1 bit: at least one operand digit was greater than 9.

Function
REQ-013 The block SHALL implement an FSM with exactly three states, IDLE, RUN and DONE, and SHALL enter IDLE on reset.
REQ-014 In IDLE, start=1 SHALL, on that edge, latch a, b and cin, clear digit index, sum, cout and err, and move to RUN.
REQ-015 start SHALL be ignored in RUN and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-016 Each RUN edge SHALL process exactly one digit i, LSD first, using one shared single-digit BCD adder.
REQ-017 The digit add SHALL compute raw = a_i + b_i + c as a 5-bit value, where c is cin for i=0 and the previous digit carry otherwise.
REQ-018 If raw > 9: sum digit i = (raw + 6)[3:0], digit carry = 1.
REQ-019 If raw <= 9: sum digit i = raw[3:0], digit carry = 0.
REQ-020 The rule in REQ-017..REQ-019 SHALL apply even to invalid digits, so raw up to 31 is handled deterministically.
REQ-021 err SHALL be set during RUN if a_i > 9 or b_i > 9 for any processed digit, and SHALL be sticky until the next accepted start.
REQ-022 After the RUN edge that processes digit NDIGITS-1, the FSM SHALL go to DONE and cout SHALL equal that digit's carry.
REQ-023 The FSM SHALL spend exactly one cycle in DONE, then return to IDLE.
REQ-024 Latency: start accepted at edge k -> busy=1 in cycles k+1 .. k+NDIGITS, done=1 in cycle k+NDIGITS+1 only.
REQ-025 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; busy and done SHALL never be 1 together.
REQ-026 sum, cout and err SHALL be valid from the DONE cycle and held through IDLE until the next accepted start.
REQ-027 During RUN, unprocessed sum digits SHALL read 0.
REQ-028 Back-to-back operation: start held high continuously SHALL yield one addition per NDIGITS+2 cycles, because start is accepted only in IDLE.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE, sum=0, cout=0, busy=0, done=0, err=0 and the digit index to 0, asynchronously to clk.
REQ-030 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and the first start after release SHALL behave as from power-up.
REQ-031 Deassertion of rst_n SHALL be treated as synchronous to clk by the integrating design; the block adds no synchronizer.

Verification (NDIGITS=4)
REQ-032 The bench SHALL drive a=0x1234, b=0x5678, cin=0, start -> after 4 busy cycles, done=1 with sum=0x6912, cout=0, err=0.
REQ-033 The bench SHALL drive a=0x9999, b=0x0001, cin=0 -> sum=0x0000, cout=1, err=0, with the carry ripple across all digits.
REQ-034 The bench SHALL drive a=0x9999, b=0x9999, cin=1 -> sum=0x9999, cout=1, err=0.
REQ-035 The bench SHALL drive a=0x00A0, b=0x0005, cin=0 -> err=1, sum=0x0105, cout=0.
REQ-036 The bench SHALL pulse start again during busy, then change a and b -> the result is unchanged from the first operands, and exactly one done pulse occurs.
REQ-037 The bench SHALL assert rst_n=0 in the 2nd RUN cycle -> all outputs are 0 immediately, no done pulse occurs, and the next start completes normally.

Source files
------------

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder: one shared single-digit BCD adder,
// processing one digit per RUN cycle, least significant digit first.
module bcd_serial_add_ctrl #(
  parameter int unsigned NDIGITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [4*NDIGITS-1:0]   a,
  input  logic [4*NDIGITS-1:0]   b,
  input  logic                   cin,
  output logic [4*NDIGITS-1:0]   sum,
  output logic                   cout,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned W  = 4 * NDIGITS;
  localparam int unsigned IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            c_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            cout_q;
  logic            err_q;
  logic            busy_q;
  logic            done_q;

  logic [3:0]      dig_a;
  logic [3:0]      dig_b;
  logic [4:0]      raw;
  logic [3:0]      raw_adj;
  logic [3:0]      dsum;
  logic            dcarry;
  logic            dig_bad;
  logic            last;

  // Select the current digit pair, run the shared BCD digit adder and
  // merge its result into the selected sum digit.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        dig_a = a_q[4*i +: 4];
        dig_b = b_q[4*i +: 4];
      end
    end
    raw     = {1'b0, dig_a} + {1'b0, dig_b} + {4'b0000, c_q};
    // Only the low nibble of raw+6 is kept, so adding in 4 bits is exact.
    raw_adj = raw[3:0] + 4'd6;
    dcarry  = (raw > 5'd9);
    dsum    = dcarry ? raw_adj : raw[3:0];
    dig_bad = (dig_a > 4'd9) || (dig_b > 4'd9);
    last    = (idx_q == IW'(NDIGITS - 1));
    sum_d   = sum_q;
    for (int unsigned i = 0; i < NDIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        sum_d[4*i +: 4] = dsum;
      end
    end
  end

  // Control FSM with registered status outputs and the datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= cin;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_q <= sum_d;
          c_q   <= dcarry;
          err_q <= err_q | dig_bad;
          if (last) begin
            cout_q  <= dcarry;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with NDIGITS=4.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        busy;
  logic        done;
  logic        err;

  int unsigned n_vec;
  int unsigned n_bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        co;
    logic        er;
  } vec_t;

  vec_t vecs [8];

  bcd_serial_add_ctrl #(.NDIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .cout  (cout),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full transaction: checks busy window, partial sums, done pulse and hold.
  task automatic run_vec(input vec_t v);
    logic [15:0] lowmask;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lowmask = 16'((32'h1 << (4*i)) - 32'h1);
      chk("busy_run", busy, 1'b1);
      chk("done_run", done, 1'b0);
      chk("partial_sum", sum, v.s & lowmask);
      @(negedge clk);
    end
    chk("busy_done", busy, 1'b0);
    chk("done_pulse", done, 1'b1);
    chk("sum", sum, v.s);
    chk("cout", cout, v.co);
    chk("err", err, v.er);
    @(negedge clk);
    chk("done_low_idle", done, 1'b0);
    chk("busy_low_idle", busy, 1'b0);
    chk("sum_held", sum, v.s);
    chk("cout_held", cout, v.co);
    chk("err_held", err, v.er);
  endtask

  int unsigned ndone;
  int unsigned d1;
  int unsigned d2;

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;

    vecs[0] = '{16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0};
    vecs[3] = '{16'h00A0, 16'h0005, 1'b0, 16'h0105, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'h0505, 16'h0505, 1'b0, 16'h1010, 1'b0, 1'b0};
    vecs[6] = '{16'h00FF, 16'h0000, 1'b0, 16'h0165, 1'b0, 1'b1};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h5555, 1'b1, 1'b1};

    // Reset state
    #12;
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) run_vec(vecs[v]);

    // Start pulsed during busy with new operands: first operands win, one done.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("restart_one_done", 16'(ndone), 16'd1);
    chk("restart_sum", sum, 16'h6912);
    chk("restart_cout", cout, 1'b0);

    // Reset in the 2nd RUN cycle aborts with no done pulse.
    @(negedge clk);
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_abort_busy", busy, 1'b1);
    @(negedge clk);
    chk("pre_abort_sum", sum, 16'h0002);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sum", sum, 16'h0000);
    chk("abort_cout", cout, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_err", err, 1'b0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 16'(ndone), 16'd0);
    run_vec(vecs[0]);

    // Start held high: one addition every NDIGITS+2 cycles.
    @(negedge clk);
    a = 16'h9999; b = 16'h0001; cin = 1'b0; start = 1'b1;
    ndone = 0; d1 = 0; d2 = 0;
    for (int t = 1; t <= 20; t++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = t;
        else if (ndone == 2) d2 = t;
      end
    end
    start = 1'b0;
    chk("b2b_spacing", 16'(d2 - d1), 16'd6);
    chk("b2b_count", 16'(ndone), 16'd3);
    repeat (8) @(negedge clk);
    chk("b2b_sum", sum, 16'h0000);
    chk("b2b_cout", cout, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
